processor_core_top: RTL and testbench
=====================================

# processor_core_top

Single-cycle execution core for the ARM data-processing instruction class: decode, 16×32 register file, barrel shifter, ALU and NZCV flags. It takes one 32-bit instruction per clock from the fetch stage and writes results back to the register file on the same edge. A separate external write port lets the bench or boot logic preload registers. Branch, load/store, multiply and PC semantics are outside this block.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_instr  in  32  instruction from fetch (ARM encoding)
- if_instr_valid  in  1  instruction present this cycle
- ext_wr_valid  in  1  external register write enable
- ext_wr_addr  in  4  external write register index
- ext_wr_data  in  32  external write data
- result  out  32  registered ALU result of last executed instruction
- result_valid  out  1  registered, high one cycle after an executed instruction
- flags  out  4  registered NZCV (bit3 N, bit2 Z, bit1 C, bit0 V)

## Operation
- Decode fields: cond[31:28], class[27:25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_imm[11:7], shift_type[6:5], bit4, Rm[3:0].
- Executed only if if_instr_valid=1, class=000, bit4=0, and cond passes. All other instructions are NOPs: no register, flag, or result update, and result_valid=0.
- Condition codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL use standard ARM definitions on the current flags. cond=1111 never executes.
- Operand2 = Rm shifted by shift_imm:
  - LSL: 0 means no shift, carry_out=C.
  - LSR and ASR: imm 0 means shift by 32.
  - ROR: imm 0 means RRX (C into bit31, carry_out=Rm[0]).
  - Otherwise carry_out is the last bit shifted out.
- Opcodes:
  - AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, ORR, MOV, BIC, MVN write Rd.
  - TST, TEQ, CMP, CMN never write Rd and execute only with S=1. With S=0 they are NOPs.
  - MOV and MVN ignore Rn.
- Arithmetic is 32-bit two's complement, modulo 2^32.
  - SUB-type ops: C = NOT borrow.
  - ADC, SBC, RSC use the current C.
- Flags update only when S=1 and the instruction executes.
  - N = result[31], Z = (result==0).
  - Arithmetic ops: C and V come from the adder.
  - Logical ops: C = shifter carry_out, V unchanged.
- Register file: 16 entries. R15 is an ordinary register with no PC behaviour. Two combinational read ports (Rn, Rm) and one write port.
- External write: when ext_wr_valid=1, write ext_wr_data to ext_wr_addr.
  - Same-cycle collision with instruction writeback to the same index: external write wins.
  - Different indices: both writes happen.
- For the four compare ops, `result` holds the computed value even though Rd is not written.

## Timing
- Reset (rst_n low, asynchronous): all 16 registers = 0, flags = 0000, result = 0, result_valid = 0. Held while low.
- Operands are read combinationally in cycle N. Writeback, flags, result and result_valid update at the rising edge ending cycle N.
- Latency 1 cycle. Throughput 1 instruction per cycle. No stalls or hazards: the instruction in cycle N+1 sees cycle N's writes and flags.
- Condition evaluation uses flags as they were before the current edge.
- Reset asserted mid-stream discards the in-flight instruction. The first instruction is accepted on the first rising edge after rst_n rises.

## Test plan
- Reset, then preload Rn=n (n=0..15) via ext port. ADD R3,R1,R2 (0xE0813002) -> R3=3, result=3, result_valid=1 next cycle, flags unchanged 0000.
- SUBS R4,R1,R2 (0xE0514002) -> R4=0xFFFFFFFF, flags N=1 Z=0 C=0 V=0.
- MOV R5,R2,LSL #4 (0xE1A05202) -> R5=0x20. Then MOVEQ R6,R1 (0x01A06001) with Z=0 -> R6 stays 6, result_valid=0.
- CMP R1,R1 (0xE1510001) -> Z=1 C=1 N=0 V=0, R1 unchanged. Next MOVEQ R6,R1 -> R6=1.
- ext write R7=0xAAAA5555 colliding with ADD R7,... in the same cycle -> R7=0xAAAA5555. Instruction with bit4=1 or class≠000 -> no state change.
- Pull rst_n low mid-stream between edges -> registers, flags, result and result_valid clear immediately, before the next clk edge.

Source files
------------

// File: rtl/processor_core_top.sv
// Single-cycle ARM data-processing core: decode, 16x32 register file,
// immediate-amount barrel shifter, ALU and NZCV flags with one-cycle writeback.
module processor_core_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_instr,
    input  logic        if_instr_valid,
    input  logic        ext_wr_valid,
    input  logic [3:0]  ext_wr_addr,
    input  logic [31:0] ext_wr_data,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [3:0]  flags
);
    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

    logic [31:0] r_regs [16];
    logic [3:0]  r_flags;
    logic [31:0] r_result;
    logic        r_result_valid;

    logic [3:0]  w_cond, w_opcode, w_rn_idx, w_rd_idx, w_rm_idx;
    logic [2:0]  w_class;
    logic [4:0]  w_shamt, w_lsl_idx, w_rgt_idx;
    logic [1:0]  w_shtype;
    logic        w_s, w_bit4;
    logic [31:0] w_rn, w_rm;
    logic        w_n, w_z, w_c, w_v;

    assign w_cond    = if_instr[31:28];
    assign w_class   = if_instr[27:25];
    assign w_opcode  = if_instr[24:21];
    assign w_s       = if_instr[20];
    assign w_rn_idx  = if_instr[19:16];
    assign w_rd_idx  = if_instr[15:12];
    assign w_shamt   = if_instr[11:7];
    assign w_shtype  = if_instr[6:5];
    assign w_bit4    = if_instr[4];
    assign w_rm_idx  = if_instr[3:0];
    assign w_rn      = r_regs[w_rn_idx];
    assign w_rm      = r_regs[w_rm_idx];
    assign {w_n, w_z, w_c, w_v} = r_flags;

    logic w_cond_pass;
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'h0: w_cond_pass = w_z;
            4'h1: w_cond_pass = !w_z;
            4'h2: w_cond_pass = w_c;
            4'h3: w_cond_pass = !w_c;
            4'h4: w_cond_pass = w_n;
            4'h5: w_cond_pass = !w_n;
            4'h6: w_cond_pass = w_v;
            4'h7: w_cond_pass = !w_v;
            4'h8: w_cond_pass = w_c && !w_z;
            4'h9: w_cond_pass = !w_c || w_z;
            4'hA: w_cond_pass = (w_n == w_v);
            4'hB: w_cond_pass = (w_n != w_v);
            4'hC: w_cond_pass = !w_z && (w_n == w_v);
            4'hD: w_cond_pass = w_z || (w_n != w_v);
            4'hE: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // LSL's last bit out is rm[32-n]; right shifts/rotates lose rm[n-1].
    assign w_lsl_idx = 5'd0 - w_shamt;
    assign w_rgt_idx = w_shamt - 5'd1;

    logic [63:0] w_ror_wide;
    logic [31:0] w_op2;
    logic        w_sh_c;
    assign w_ror_wide = {w_rm, w_rm} >> w_shamt;

    always_comb begin
        w_op2  = w_rm;
        w_sh_c = w_c;
        case (w_shtype)
            2'b00: if (w_shamt != 5'd0) begin
                w_op2  = w_rm << w_shamt;
                w_sh_c = w_rm[w_lsl_idx];
            end
            2'b01: if (w_shamt == 5'd0) begin
                w_op2  = 32'd0;
                w_sh_c = w_rm[31];
            end else begin
                w_op2  = w_rm >> w_shamt;
                w_sh_c = w_rm[w_rgt_idx];
            end
            2'b10: if (w_shamt == 5'd0) begin
                w_op2  = {32{w_rm[31]}};
                w_sh_c = w_rm[31];
            end else begin
                w_op2  = $unsigned($signed(w_rm) >>> w_shamt);
                w_sh_c = w_rm[w_rgt_idx];
            end
            default: if (w_shamt == 5'd0) begin
                w_op2  = {w_c, w_rm[31:1]};
                w_sh_c = w_rm[0];
            end else begin
                w_op2  = w_ror_wide[31:0];
                w_sh_c = w_rm[w_rgt_idx];
            end
        endcase
    end

    // Every arithmetic op is one adder: subtraction feeds ~operand with carry-in.
    logic [31:0] w_a, w_b, w_logic_res, w_alu;
    logic        w_cin, w_arith, w_add_v;
    logic [32:0] w_sum;

    always_comb begin
        w_a         = w_rn;
        w_b         = w_op2;
        w_cin       = 1'b0;
        w_arith     = 1'b0;
        w_logic_res = 32'd0;
        case (w_opcode)
            OP_AND, OP_TST: w_logic_res = w_rn & w_op2;
            OP_EOR, OP_TEQ: w_logic_res = w_rn ^ w_op2;
            OP_SUB, OP_CMP: begin w_b = ~w_op2; w_cin = 1'b1; w_arith = 1'b1; end
            OP_RSB:         begin w_a = w_op2; w_b = ~w_rn; w_cin = 1'b1; w_arith = 1'b1; end
            OP_ADD, OP_CMN: w_arith = 1'b1;
            OP_ADC:         begin w_cin = w_c; w_arith = 1'b1; end
            OP_SBC:         begin w_b = ~w_op2; w_cin = w_c; w_arith = 1'b1; end
            OP_RSC:         begin w_a = w_op2; w_b = ~w_rn; w_cin = w_c; w_arith = 1'b1; end
            OP_ORR:         w_logic_res = w_rn | w_op2;
            OP_MOV:         w_logic_res = w_op2;
            OP_BIC:         w_logic_res = w_rn & ~w_op2;
            default:        w_logic_res = ~w_op2;
        endcase
    end

    assign w_sum   = {1'b0, w_a} + {1'b0, w_b} + {32'd0, w_cin};
    assign w_alu   = w_arith ? w_sum[31:0] : w_logic_res;
    assign w_add_v = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);

    logic w_is_cmp, w_exec, w_wb;
    assign w_is_cmp = (w_opcode[3:2] == 2'b10);
    assign w_exec   = if_instr_valid && (w_class == 3'b000) && !w_bit4 && w_cond_pass
                      && (!w_is_cmp || w_s);
    assign w_wb     = w_exec && !w_is_cmp;

    // The external write is applied last so it wins a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= 32'd0;
        end else begin
            if (w_wb) r_regs[w_rd_idx] <= w_alu;
            if (ext_wr_valid) r_regs[ext_wr_addr] <= ext_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags        <= 4'b0000;
            r_result       <= 32'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_exec;
            if (w_exec) r_result <= w_alu;
            if (w_exec && w_s) begin
                r_flags[3] <= w_alu[31];
                r_flags[2] <= (w_alu == 32'd0);
                r_flags[1] <= w_arith ? w_sum[32] : w_sh_c;
                r_flags[0] <= w_arith ? w_add_v : w_v;
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign flags        = r_flags;
endmodule

// File: tb/tb_processor_core_top.sv
// Bench for processor_core_top: directed scenarios plus randomized instructions
// compared against a behavioural model of the ARM data-processing rules.
module tb_processor_core_top;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_instr = 32'd0;
    logic        if_instr_valid = 1'b0;
    logic        ext_wr_valid = 1'b0;
    logic [3:0]  ext_wr_addr = 4'd0;
    logic [31:0] ext_wr_data = 32'd0;
    logic [31:0] result;
    logic        result_valid;
    logic [3:0]  flags;

    processor_core_top dut (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_instr_valid(if_instr_valid),
        .ext_wr_valid(ext_wr_valid), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .result(result), .result_valid(result_valid), .flags(flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    logic [31:0] m_res;
    logic        m_valid;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_flags = 4'b0000;
        m_res   = 32'd0;
        m_valid = 1'b0;
    endtask

    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // x + y + cin and x - y - borrow evaluated in 64-bit integer arithmetic.
    task automatic do_add(input logic [31:0] x, input logic [31:0] y, input int cin,
                          output logic [31:0] r, output bit c, output bit v);
        longint u, s;
        u = longint'(x) + longint'(y) + longint'(cin);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
        r = u[31:0];
        c = (u > 64'sd4294967295);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    task automatic do_sub(input logic [31:0] x, input logic [31:0] y, input int bw,
                          output logic [31:0] r, output bit c, output bit v);
        longint u, s;
        u = longint'(x) - longint'(y) - longint'(bw);
        s = longint'($signed(x)) - longint'($signed(y)) - longint'(bw);
        r = u[31:0];
        c = (u >= 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    task automatic model_step(input logic [31:0] ins, input logic v_in, input logic ew,
                              input logic [3:0] ea, input logic [31:0] ed);
        logic [3:0]  op;
        logic [31:0] rn, rm, op2, res;
        int          amt;
        bit          sh_c, ac, av, arith, exec, cmp, cf;
        logic [63:0] t;
        logic signed [63:0] st;
        op   = ins[24:21];
        rn   = m_regs[ins[19:16]];
        rm   = m_regs[ins[3:0]];
        amt  = int'(ins[11:7]);
        cf   = m_flags[1];
        cmp  = (op >= 4'h8) && (op <= 4'hB);
        exec = v_in && ins[27:25] == 3'b000 && !ins[4] && cond_ok(ins[31:28], m_flags)
               && !(cmp && !ins[20]);
        case (ins[6:5])
            2'b00: if (amt == 0) begin op2 = rm; sh_c = cf; end
                   else begin t = {32'd0, rm} << amt; op2 = t[31:0]; sh_c = t[32]; end
            2'b01: begin t = {rm, 32'd0} >> (amt == 0 ? 32 : amt); op2 = t[63:32]; sh_c = t[31]; end
            2'b10: begin st = {rm, 32'd0}; st = st >>> (amt == 0 ? 32 : amt);
                         op2 = st[63:32]; sh_c = st[31]; end
            default: if (amt == 0) begin op2 = {cf, rm[31:1]}; sh_c = rm[0]; end
                     else begin op2 = (rm >> amt) | (rm << (32 - amt)); sh_c = op2[31]; end
        endcase
        arith = 1'b1; ac = 1'b0; av = 1'b0;
        case (op)
            4'h0, 4'h8: begin res = rn & op2; arith = 1'b0; end
            4'h1, 4'h9: begin res = rn ^ op2; arith = 1'b0; end
            4'h2, 4'hA: do_sub(rn, op2, 0, res, ac, av);
            4'h3:       do_sub(op2, rn, 0, res, ac, av);
            4'h4, 4'hB: do_add(rn, op2, 0, res, ac, av);
            4'h5:       do_add(rn, op2, int'(cf), res, ac, av);
            4'h6:       do_sub(rn, op2, int'(!cf), res, ac, av);
            4'h7:       do_sub(op2, rn, int'(!cf), res, ac, av);
            4'hC:       begin res = rn | op2; arith = 1'b0; end
            4'hD:       begin res = op2; arith = 1'b0; end
            4'hE:       begin res = rn & ~op2; arith = 1'b0; end
            default:    begin res = ~op2; arith = 1'b0; end
        endcase
        m_valid = exec;
        if (exec) begin
            m_res = res;
            if (ins[20]) m_flags = {res[31], res == 32'd0, arith ? ac : sh_c, arith ? av : m_flags[0]};
            if (!cmp) m_regs[ins[15:12]] = res;
        end
        if (ew) m_regs[ea] = ed;
        exp_q.push_back(m_res);
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic v_in,
                        input logic ew, input logic [3:0] ea, input logic [31:0] ed);
        @(negedge clk);
        if_instr = ins; if_instr_valid = v_in;
        ext_wr_valid = ew; ext_wr_addr = ea; ext_wr_data = ed;
        model_step(ins, v_in, ew, ea, ed);
        @(posedge clk);
        #1;
        chk({tag, ".result"}, result, exp_q.pop_front());
        chk({tag, ".result_valid"}, {31'd0, result_valid}, {31'd0, m_valid});
        chk({tag, ".flags"}, {28'd0, flags}, {28'd0, m_flags});
        if_instr_valid = 1'b0;
        ext_wr_valid = 1'b0;
    endtask

    task automatic read_reg(input int i);
        logic [31:0] ins;
        ins = 32'hE1A00000;
        ins[15:12] = i[3:0];
        ins[3:0] = i[3:0];
        step($sformatf("read_r%0d", i), ins, 1'b1, 1'b0, 4'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] cond;
        logic [2:0] cls;
        logic [4:0] shamt;
        logic       b4;
        cond  = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
        cls   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        b4    = ($urandom_range(0, 9) == 0);
        shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        return {cond, cls, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), shamt,
                2'($urandom_range(0, 3)), b4, 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.result", result, 32'd0);
        chk("reset.result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset.flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 16; n++) step("preload", 32'd0, 1'b0, 1'b1, 4'(n), 32'(n));

        step("add_r3", 32'hE0813002, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("add_r3.const", result, 32'd3);
        chk("add_r3.flags_const", {28'd0, flags}, 32'h0);
        step("subs_r4", 32'hE0514002, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("subs_r4.const", result, 32'hFFFFFFFF);
        chk("subs_r4.flags_const", {28'd0, flags}, 32'h8);
        step("mov_lsl", 32'hE1A05202, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("mov_lsl.const", result, 32'h20);
        step("moveq_skip", 32'h01A06001, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("moveq_skip.valid_const", {31'd0, result_valid}, 32'd0);
        step("cmp_r1", 32'hE1510001, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("cmp_r1.flags_const", {28'd0, flags}, 32'h6);
        step("moveq_take", 32'h01A06001, 1'b1, 1'b0, 4'd0, 32'd0);
        read_reg(6);
        chk("r6.const", result, 32'd1);
        step("collide_r7", 32'hE0817002, 1'b1, 1'b1, 4'd7, 32'hAAAA5555);
        read_reg(7);
        chk("r7.const", result, 32'hAAAA5555);
        step("bit4_nop", 32'hE0818012, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("bit4_nop.valid_const", {31'd0, result_valid}, 32'd0);
        step("class_nop", 32'hE2818002, 1'b1, 1'b0, 4'd0, 32'd0);
        step("ext_diff", 32'hE0819002, 1'b1, 1'b1, 4'd10, 32'h0BADF00D);
        for (int i = 0; i < 16; i++) read_reg(i);

        for (int i = 0; i < 16; i++) step("rand_load", 32'd0, 1'b0, 1'b1, 4'(i), $urandom);
        for (int k = 0; k < 400; k++) begin
            logic ew;
            ew = ($urandom_range(0, 3) == 0);
            step("rand", rand_instr(), $urandom_range(0, 9) != 0, ew,
                 4'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < 16; i++) read_reg(i);

        step("pre_rst_load", 32'd0, 1'b0, 1'b1, 4'd9, 32'h00001234);
        step("pre_rst_cmp", 32'hE1590009, 1'b1, 1'b0, 4'd0, 32'd0);
        step("pre_rst_mvn", 32'hE1E0A009, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("pre_rst_mvn.const", result, 32'hFFFFEDCB);
        @(negedge clk);
        if_instr = 32'hE0813002;
        if_instr_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.result", result, 32'd0);
        chk("async_rst.result_valid", {31'd0, result_valid}, 32'd0);
        chk("async_rst.flags", {28'd0, flags}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_held.result_valid", {31'd0, result_valid}, 32'd0);
        if_instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) read_reg(i);
        chk("post_rst.r15_const", result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
